// File: rtl/rf_accum_engine.sv
// rf_accum_engine
// Self-sequencing accumulate engine. On an accepted start it computes
// sum(1..limit) modulo 2^DATA_W using a small register file, a single
// adder and an unsigned compare, all sequenced by an internal FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      run request, sampled only while idle
//   limit      upper bound N, latched when start is accepted
//   busy       high whenever the engine is not idle
//   done       one-cycle pulse when the run completes
//   out_valid  one-cycle pulse, coincident with done
//   out_port   registered result, held until the next completion
//   overflow   sticky carry-out flag for the current/last run
//   dbg_addr   debug read address into the register file
//   dbg_data   combinational debug read data (address 0 reads 0)

module rf_accum_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] limit,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_port,
    output logic              overflow,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_I,
        INIT_S,
        CHECK,
        ACC,
        INC,
        DONE
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [ADDR_W-1:0] I_ADDR    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SUM_ADDR  = ADDR_W'(2);
    localparam logic [DATA_W-1:0] MAX_VAL   = '1;
    localparam logic [DATA_W-1:0] IMM_ONE   = DATA_W'(1);

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DATA_W-1:0] limit_q;

    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              use_imm;

    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;
    logic              carry;
    logic              i_le_limit;
    logic              i_at_max;

    // Entry 0 reads as zero regardless of array contents
    assign rd1_data = (rd1_addr == ZERO_ADDR) ? '0 : rf[rd1_addr];
    assign rd2_data = (rd2_addr == ZERO_ADDR) ? '0 : rf[rd2_addr];
    assign dbg_data = (dbg_addr == ZERO_ADDR) ? '0 : rf[dbg_addr];

    // The extra top bit of the adder is the carry-out used for overflow
    assign alu_b      = use_imm ? IMM_ONE : rd2_data;
    assign alu_sum    = {1'b0, rd1_data} + {1'b0, alu_b};
    assign carry      = alu_sum[DATA_W];
    assign i_le_limit = (rd2_data <= limit_q);
    assign i_at_max   = (rd1_data == MAX_VAL);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // INC stops at the all-ones value so the counter never wraps to zero,
    // which would otherwise make i <= limit true forever.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = INIT_I;
            INIT_I:  next_state = INIT_S;
            INIT_S:  next_state = CHECK;
            CHECK:   next_state = i_le_limit ? ACC : DONE;
            ACC:     next_state = INC;
            INC:     next_state = i_at_max ? DONE : CHECK;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Initialisation reuses the adder: 0 + 1 loads i, 0 + 0 clears sum.
    always_comb begin
        rd1_addr = ZERO_ADDR;
        rd2_addr = ZERO_ADDR;
        wr_addr  = ZERO_ADDR;
        wr_en    = 1'b0;
        use_imm  = 1'b0;
        case (state)
            INIT_I: begin
                use_imm = 1'b1;
                wr_en   = 1'b1;
                wr_addr = I_ADDR;
            end
            INIT_S: begin
                wr_en   = 1'b1;
                wr_addr = SUM_ADDR;
            end
            CHECK: begin
                rd2_addr = I_ADDR;
            end
            ACC: begin
                rd1_addr = SUM_ADDR;
                rd2_addr = I_ADDR;
                wr_en    = 1'b1;
                wr_addr  = SUM_ADDR;
            end
            INC: begin
                rd1_addr = I_ADDR;
                use_imm  = 1'b1;
                wr_en    = !i_at_max;
                wr_addr  = I_ADDR;
            end
            DONE: begin
                rd1_addr = SUM_ADDR;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf[k] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            rf[wr_addr] <= alu_sum[DATA_W-1:0];
        end
    end

    // overflow is cleared only by an accepted start, so it survives idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q  <= '0;
            overflow <= 1'b0;
            out_port <= '0;
        end else begin
            if (state == IDLE && start) begin
                limit_q  <= limit;
                overflow <= 1'b0;
            end
            if (state == ACC && carry) begin
                overflow <= 1'b1;
            end
            if (state == DONE) begin
                out_port <= rd1_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_accum_engine.sv
// tb_rf_accum_engine
// Self-checking bench for rf_accum_engine (DATA_W=8, ADDR_W=2). Expected
// results come from closed-form arithmetic: the true sum N(N+1)/2, its
// value modulo 256, whether it ever exceeded 255, the final counter value
// and the cycle count of a run.

module tb_rf_accum_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int BOUND  = 2000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] limit;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [DATA_W-1:0] out_port;
    logic              overflow;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int tests_run;
    int tests_failed;

    rf_accum_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .limit     (limit),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_port  (out_port),
        .overflow  (overflow),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: result, overflow, final counter and latency of a run
    function automatic longint modelSum(input int n);
        longint total = longint'(n) * longint'(n + 1) / 2;
        return total % 256;
    endfunction

    function automatic longint modelOvf(input int n);
        longint total = longint'(n) * longint'(n + 1) / 2;
        return (total > 255) ? 1 : 0;
    endfunction

    function automatic longint modelLatency(input int n);
        return (n == 255) ? 3 * n + 3 : 3 * n + 4;
    endfunction

    function automatic longint modelFinalI(input int n);
        return (n == 255) ? 255 : n + 1;
    endfunction

    // Called at a negedge while idle. With disturb set, start is pulsed and
    // limit changed to 3 mid-run, both of which must be ignored.
    task automatic applyStimulus(input int n, input bit disturb);
        int cyc;
        cyc   = 0;
        limit = DATA_W'(n);
        start = 1'b1;
        while (cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (disturb && cyc == 5) begin
                start = 1'b1;
                limit = 8'd3;
            end
            if (disturb && cyc == 6) start = 1'b0;
            if (done) break;
        end
        checkOutput($sformatf("latency_n%0d", n), cyc, modelLatency(n));
        checkOutput($sformatf("out_valid_n%0d", n), out_valid, 1);
        checkOutput($sformatf("busy_in_done_n%0d", n), busy, 1);
        @(negedge clk);
        checkOutput($sformatf("done_single_n%0d", n), done, 0);
        checkOutput($sformatf("busy_after_n%0d", n), busy, 0);
        checkOutput($sformatf("out_port_n%0d", n), out_port, modelSum(n));
        checkOutput($sformatf("overflow_n%0d", n), overflow, modelOvf(n));
        dbg_addr = 2'd2;
        #1 checkOutput($sformatf("dbg_sum_n%0d", n), dbg_data, modelSum(n));
        dbg_addr = 2'd1;
        #1 checkOutput($sformatf("dbg_i_n%0d", n), dbg_data, modelFinalI(n));
        dbg_addr = 2'd0;
        #1 checkOutput($sformatf("dbg_zero_n%0d", n), dbg_data, 0);
    endtask

    initial begin
        int n;
        int cnt;
        int last;
        int pulses;
        bit check_next;

        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        limit    = '0;
        dbg_addr = '0;

        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_port", out_port, 0);
        checkOutput("reset_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(10, 1'b0);
        applyStimulus(0, 1'b0);
        applyStimulus(22, 1'b0);
        applyStimulus(23, 1'b0);
        applyStimulus(10, 1'b1);
        applyStimulus(3, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = (k < 4) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 254));
            applyStimulus(n, 1'b0);
        end

        applyStimulus(255, 1'b0);
        applyStimulus(23, 1'b0);

        // Reset mid-run: everything clears immediately, no done follows
        limit = 8'd10;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_port", out_port, 0);
        checkOutput("midrst_overflow", overflow, 0);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = ADDR_W'(a);
            #1 checkOutput($sformatf("midrst_dbg%0d", a), dbg_data, 0);
        end
        dbg_addr = '0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", pulses, 0);
        applyStimulus(4, 1'b0);

        // start held high: back-to-back runs every 11 cycles
        limit      = 8'd2;
        start      = 1'b1;
        cnt        = 0;
        last       = 0;
        pulses     = 0;
        check_next = 1'b0;
        while (cnt < 200 && pulses < 4) begin
            @(negedge clk);
            cnt++;
            if (check_next) begin
                checkOutput("b2b_out_port", out_port, 3);
                check_next = 1'b0;
            end
            if (done) begin
                if (pulses > 0) checkOutput("b2b_gap", cnt - last, 11);
                last = cnt;
                pulses++;
                check_next = 1'b1;
                if (pulses == 4) start = 1'b0;
            end
        end
        checkOutput("b2b_pulses", pulses, 4);
        @(negedge clk);
        checkOutput("b2b_final_out_port", out_port, 3);
        @(negedge clk);
        checkOutput("b2b_stopped", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rf_accum_engine.md
Name: rf_accum_engine

Overview:
Self-sequencing accumulate engine: parametrised register file, ALU path and compare path, driven by an internal FSM.
- Computes sum(1..limit) modulo 2^DATA_W on a start/busy/done handshake.
- Presents the result on a registered output port.
- Successor to the externally-controlled 8-bit/8-entry datapath: generalised width and depth, file reset, sticky overflow, debug read port, on-chip control.

Parameters:
DATA_W, 8, datapath and register-file entry width (>= 2)
ADDR_W, 2, register-file address width; 2**ADDR_W entries (>= 2; entries 1 and 2 are used by the FSM)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
limit  input  DATA_W  upper bound N, unsigned; latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
out_valid  output  1  one-cycle pulse, coincident with done
out_port  output  DATA_W  registered result; holds until next DONE
overflow  output  1  sticky carry-out flag for current/last run
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  DATA_W  combinational read of file[dbg_addr]; address 0 reads 0

Behaviour:
- Reset (async, any state): FSM to IDLE; all file entries, limit_q, out_port and overflow go to 0; busy, done and out_valid are 0. Reset mid-run aborts the run with no done pulse.
- Register file:
  - One write port (write at posedge) and two internal combinational read ports, plus the dbg port.
  - Entry 0 is hardwired zero; writes to it are ignored.
  - Entry 1 = i; entry 2 = sum.
- ALU: DATA_W-bit add; operand B muxed between read port 2 and the immediate 1. Carry-out is observed only in ACC. Compare is unsigned, i <= limit_q.
- FSM states and transitions:
  - IDLE: if start, latch limit into limit_q, clear overflow, go INIT_I. Otherwise stay.
  - INIT_I: write i <= 1; go INIT_S.
  - INIT_S: write sum <= 0; go CHECK.
  - CHECK: no write. If i <= limit_q go ACC, else go DONE.
  - ACC: write sum <= sum + i (mod 2^DATA_W); if carry-out, overflow <= 1. Go INC.
  - INC:
    - If i == 2^DATA_W-1, go DONE without writing, so i never wraps to 0.
    - Otherwise write i <= i + 1 and go CHECK.
  - DONE: out_port <= sum (visible the next cycle); done = out_valid = 1 for this one cycle; go IDLE.
- Latency: count clocks from the accepting edge (start sampled high in IDLE) to the cycle in which done is high.
  - Normal case: 3N+4.
  - N = 2^DATA_W-1: 3N+3, because the terminal CHECK is skipped.
- start while busy is ignored, with no queuing. start held high through DONE re-launches the next run the cycle after DONE.
- limit changes after acceptance have no effect.
- out_port and overflow retain their values in IDLE. overflow clears only on an accepted start or on reset.

Test Plan:
1. DATA_W=8, limit=10, start 1 cycle -> busy high; done/out_valid pulse 34 clocks after accept; out_port=55, overflow=0; dbg_addr=2 reads 55, dbg_addr=1 reads 11, dbg_addr=0 reads 0.
2. limit=0 -> done at 4 clocks, out_port=0, overflow=0. Then limit=22 -> out_port=253, overflow=0. Then limit=23 -> out_port=20 (276 mod 256), overflow=1.
3. limit=255 -> terminates without hang; done at 768 clocks; out_port=128 (32640 mod 256), overflow=1; dbg_addr=1 reads 255.
4. Accept limit=10; pulse start and change limit to 3 while busy -> both ignored, out_port=55, single done pulse. Next start with limit=3 -> out_port=6 and overflow cleared to 0.
5. Assert rst mid-run (cycle 15 of limit=10) -> same cycle: busy=0, out_port=0, overflow=0, dbg reads 0 at all addresses; no done. After release, start limit=4 -> out_port=10 at 16 clocks.
6. Hold start high continuously with limit=2 -> back-to-back runs, done pulses every 11 clocks (10-clock run + 1 IDLE cycle), out_port=3 each time.
